// File: rtl/contador_defs.sv
// Shared mode encodings for the contador_param counter family.
package contador_defs;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_STEP = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

endpackage

// File: rtl/contador_param_next.sv
// Next-state logic for contador_param: count value, boundary pulse and load-range error.
module contador_param_next
  import contador_defs::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 2 ** WIDTH,
  parameter int STEP     = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] d,
  input  logic             enable,
  input  logic             ci,
  output logic [WIDTH-1:0] next_q,
  output logic             next_rco,
  output logic             next_err
);

  // One extra bit so q + STEP cannot overflow before the range compare.
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] MOD_LO = WIDTH'(MODULO);
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULO - 1);

  logic [WIDTH:0]   step_amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wrapped;

  always_comb begin
    step_amt = (modo == MODO_STEP) ? STEP_W : (WIDTH + 1)'(1);
    sum      = {1'b0, q} + step_amt;
    // Low bits of (sum - MODULO); exact because the true result is below MODULO.
    wrapped  = sum[WIDTH-1:0] - MOD_LO;

    next_q   = q;
    next_rco = 1'b0;
    next_err = 1'b0;

    if (enable) begin
      if (modo == MODO_LOAD) begin
        if ({1'b0, d} < MOD_W) begin
          next_q = d;
        end else begin
          next_q   = MAX_Q;
          next_err = 1'b1;
        end
      end else if (ci) begin
        if (modo == MODO_DOWN) begin
          if (q != '0) begin
            next_q = q - WIDTH'(1);
          end else begin
            next_q   = SATURATE ? '0 : MAX_Q;
            next_rco = 1'b1;
          end
        end else begin
          if (sum < MOD_W) begin
            next_q = sum[WIDTH-1:0];
          end else begin
            next_q   = SATURATE ? MAX_Q : wrapped;
            next_rco = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/contador_param.sv
// Parametrised modulo-N up/down/step counter with synchronous load and cascade carry.
module contador_param
  import contador_defs::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 2 ** WIDTH,
  parameter int STEP     = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ci,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load_err
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             rco_q, rco_d;
  logic             err_q, err_d;

  contador_param_next #(
    .WIDTH   (WIDTH),
    .MODULO  (MODULO),
    .STEP    (STEP),
    .SATURATE(SATURATE)
  ) u_next (
    .q       (count_q),
    .modo    (modo),
    .d       (D),
    .enable  (enable),
    .ci      (ci),
    .next_q  (count_d),
    .next_rco(rco_d),
    .next_err(err_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      rco_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      rco_q   <= rco_d;
      err_q   <= err_d;
    end
  end

  assign Q        = count_q;
  assign rco      = rco_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: wrap, saturate and cascaded instances.
module tb_contador_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Wrapping instance under main test
  logic       en_a = 1'b0, ci_a = 1'b1;
  logic [1:0] modo_a = 2'b00;
  logic [3:0] d_a = 4'd0, q_a;
  logic       rco_a, err_a;

  // Saturating instance
  logic       en_s = 1'b0, ci_s = 1'b1;
  logic [1:0] modo_s = 2'b00;
  logic [3:0] d_s = 4'd0, q_s;
  logic       rco_s, err_s;

  // Cascaded pair
  logic       en_c = 1'b0;
  logic [3:0] q_lo, q_hi;
  logic       rco_lo, rco_hi, err_lo, err_hi;

  contador_param #(.WIDTH(4), .MODULO(10), .STEP(3), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .ci(ci_a), .modo(modo_a), .D(d_a),
    .Q(q_a), .rco(rco_a), .load_err(err_a));

  contador_param #(.WIDTH(4), .MODULO(10), .STEP(3), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .enable(en_s), .ci(ci_s), .modo(modo_s), .D(d_s),
    .Q(q_s), .rco(rco_s), .load_err(err_s));

  contador_param #(.WIDTH(4), .MODULO(10), .STEP(3), .SATURATE(1'b0)) dut_lo (
    .clk(clk), .reset(reset), .enable(en_c), .ci(1'b1), .modo(2'b00), .D(4'd0),
    .Q(q_lo), .rco(rco_lo), .load_err(err_lo));

  contador_param #(.WIDTH(4), .MODULO(10), .STEP(3), .SATURATE(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .enable(en_c), .ci(rco_lo), .modo(2'b00), .D(4'd0),
    .Q(q_hi), .rco(rco_hi), .load_err(err_hi));

  typedef struct {
    logic       en;
    logic       ci;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Stimulus table for dut_a, starting from Q=0 after reset
    for (int i = 1; i <= 10; i++)
      vecs.push_back('{1'b1, 1'b1, 2'b00, 4'd0, 4'(i % 10), (i == 10), 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 4'd1,  4'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b01, 4'd0,  4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b01, 4'd0,  4'd9, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 4'd8,  4'd8, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 4'd0,  4'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 4'd0,  4'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 4'd0,  4'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 4'd5,  4'd5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 4'd12, 4'd9, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 4'd7,  4'd7, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 4'd10, 4'd9, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 4'd9,  4'd9, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 4'd0,  4'd9, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 4'd0,  4'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b01, 4'd0,  4'd9, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 4'd3,  4'd9, 1'b0, 1'b0});

    // Reset held across edges, then released
    tick();
    chk("reset_q", 8'(q_a), 8'd0);
    chk("reset_rco", 8'(rco_a), 8'd0);
    chk("reset_err", 8'(err_a), 8'd0);
    reset = 1'b0;

    // Count a little, then assert reset between edges: outputs clear at once
    en_a = 1'b1; modo_a = 2'b00;
    for (int i = 1; i <= 3; i++) tick();
    chk("precount_q", 8'(q_a), 8'd3);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_q", 8'(q_a), 8'd0);
    chk("async_reset_rco", 8'(rco_a), 8'd0);
    tick();
    reset = 1'b0;
    en_a = 1'b0;
    $display("reset sequence done q=%0d", q_a);

    // Table-driven vectors on the wrapping instance
    for (int i = 0; i < vecs.size(); i++) begin
      en_a = vecs[i].en; ci_a = vecs[i].ci; modo_a = vecs[i].modo; d_a = vecs[i].d;
      tick();
      $display("vec %0d en=%0b ci=%0b modo=%0d d=%0d -> q=%0d rco=%0b err=%0b",
               i, vecs[i].en, vecs[i].ci, vecs[i].modo, vecs[i].d, q_a, rco_a, err_a);
      chk($sformatf("vec%0d_q", i), 8'(q_a), 8'(vecs[i].q));
      chk($sformatf("vec%0d_rco", i), 8'(rco_a), 8'(vecs[i].rco));
      chk($sformatf("vec%0d_err", i), 8'(err_a), 8'(vecs[i].err));
    end
    en_a = 1'b0; ci_a = 1'b1;

    // Saturating instance: clamp at top, rco repeats each cycle
    en_s = 1'b1; modo_s = 2'b11; d_s = 4'd9;
    tick();
    chk("sat_load9_q", 8'(q_s), 8'd9);
    modo_s = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("sat up cycle %0d q=%0d rco=%0b", i, q_s, rco_s);
      chk($sformatf("sat_up%0d_q", i), 8'(q_s), 8'd9);
      chk($sformatf("sat_up%0d_rco", i), 8'(rco_s), 8'd1);
    end
    modo_s = 2'b11; d_s = 4'd8;
    tick();
    chk("sat_load8_rco", 8'(rco_s), 8'd0);
    modo_s = 2'b10;
    tick();
    $display("sat step q=%0d rco=%0b", q_s, rco_s);
    chk("sat_step_q", 8'(q_s), 8'd9);
    chk("sat_step_rco", 8'(rco_s), 8'd1);
    modo_s = 2'b11; d_s = 4'd0;
    tick();
    chk("sat_load0_q", 8'(q_s), 8'd0);
    chk("sat_load0_rco", 8'(rco_s), 8'd0);
    modo_s = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      $display("sat down cycle %0d q=%0d rco=%0b", i, q_s, rco_s);
      chk($sformatf("sat_dn%0d_q", i), 8'(q_s), 8'd0);
      chk($sformatf("sat_dn%0d_rco", i), 8'(rco_s), 8'd1);
    end
    en_s = 1'b0;

    // Cascaded pair: upper stage steps one cycle after each lower wrap
    begin
      int lo_m, hi_m;
      bit rco_m;
      lo_m = 0; hi_m = 0; rco_m = 1'b0;
      en_c = 1'b1;
      for (int i = 1; i <= 25; i++) begin
        tick();
        hi_m  = rco_m ? (hi_m + 1) % 10 : hi_m;
        rco_m = (lo_m + 1 == 10);
        lo_m  = (lo_m + 1) % 10;
        $display("chain cycle %0d lo=%0d hi=%0d rco_lo=%0b", i, q_lo, q_hi, rco_lo);
        chk($sformatf("chain%0d_lo", i), 8'(q_lo), 8'(lo_m));
        chk($sformatf("chain%0d_hi", i), 8'(q_hi), 8'(hi_m));
        chk($sformatf("chain%0d_rco", i), 8'(rco_lo), 8'(rco_m));
        if (i == 10) chk("chain_hi_before_step", 8'(q_hi), 8'd0);
        if (i == 11) chk("chain_hi_after_step", 8'(q_hi), 8'd1);
      end
      en_c = 1'b0;
      chk("chain_final_lo", 8'(q_lo), 8'd5);
      chk("chain_final_hi", 8'(q_hi), 8'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_param.md
Name: contador_param

Overview:
- Parametrised successor of the 4-bit contadorA: a modulo-N up/down/step counter with synchronous load.
- Adds over the fixed-width counter: configurable width and modulus, configurable step size, wrap-or-saturate policy, cascade carry-in, and load-range error flag.
- Sits as a leaf timing/sequence counter; multiple instances chain through rco -> ci for wider counts.

Parameters:
- WIDTH, 4, bit width of D and Q.
- MODULO, 2**WIDTH, count range is 0..MODULO-1; legal range 2..2**WIDTH.
- STEP, 3, increment used in modo 2'b10; legal range 1..MODULO-1.
- SATURATE, 0, 0 = wrap at range ends; 1 = clamp at range ends.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  block enable; when 0 nothing changes except rco/load_err clearing.
- ci  input  1  cascade carry-in; gates counting modes only, not load. Tie to 1 when unused.
- modo  input  2  mode select: 00 up by 1, 01 down by 1, 10 up by STEP, 11 load D.
- D  input  WIDTH  load value.
- Q  output  WIDTH  registered count.
- rco  output  1  registered ripple-carry/boundary pulse.
- load_err  output  1  registered; pulses on an out-of-range load.

Behaviour:
- Reset, async while reset=1: Q=0, rco=0, load_err=0. Release takes effect at the first clk edge after deassertion. Reset mid-count discards the current value.
- All updates happen on the rising clk edge. Q, rco and load_err are registered, so latency is 1 cycle from inputs to outputs.
- Default every edge: rco=0, load_err=0, unless one of the rules below sets them.
- enable=0: Q holds.
- Counting step = 1 for modo 00/01, STEP for modo 10. Counting occurs only when enable=1 and ci=1. With ci=0, Q holds and rco=0.
- Up count, SATURATE=0:
  - If Q+step < MODULO, then Q <= Q+step.
  - Otherwise Q <= Q+step-MODULO and rco=1.
- Down count, SATURATE=0:
  - If Q >= 1, then Q <= Q-1.
  - Otherwise (Q=0), Q <= MODULO-1 and rco=1.
- SATURATE=1:
  - Up: if Q+step >= MODULO, Q <= MODULO-1 and rco=1. rco repeats every cycle the overflow condition persists.
  - Down: at Q=0, Q stays 0 and rco=1.
- Internal arithmetic uses WIDTH+1 bits so Q+STEP never overflows before comparison.
- Load (modo 11, enable=1, ci ignored):
  - If D < MODULO, Q <= D.
  - Otherwise Q <= MODULO-1 and load_err=1.
  - rco=0 on a load.
- rco is high in the same cycle that Q shows the wrapped/clamped value, and lasts one cycle per event.
- Cascade: the upper stage's ci is driven from the lower stage's rco. The upper stage therefore steps one cycle after the lower stage wraps; this skew is accepted.
- No FSM beyond the count register. Mode changes take effect on the next edge with no pipeline flush.

Decomposition:
- Shared package/header (contador_defs): mode constants MODO_UP=2'b00, MODO_DOWN=2'b01, MODO_STEP=2'b10, MODO_LOAD=2'b11.
- One natural combinational sub-module, contador_param_next:
  - Inputs: Q, modo, D, the enable/ci qualifiers, and the parameters.
  - Outputs: next_q, next_rco, next_err.
  - The top level holds only the registers and the async reset.

Test Plan:
- reset=1 during counting with WIDTH=4, MODULO=10, STEP=3 -> Q=0, rco=0, load_err=0 immediately, without waiting for a clk edge.
- From Q=0, modo=00, enable=1, ci=1 for 10 cycles -> Q=1..9 then 0; rco=1 only in the cycle Q=0.
- Load D=1, then modo=01 for 2 cycles -> Q=0 then 9 with rco=1; then set enable=0 for 3 cycles -> Q holds 9, rco=0.
- Load D=8, then modo=10 -> Q=1 with rco=1; next cycle Q=4 with rco=0. Then ci=0 -> Q holds 4; a load with D=5 while ci=0 -> Q=5.
- Load D=12 -> Q=9 and load_err=1 for one cycle; a following load with D=7 -> Q=7 and load_err=0.
- SATURATE=1 instance at Q=9, modo=00 for 3 cycles -> Q stays 9 and rco=1 each cycle; load 0 then modo=01 -> Q stays 0 and rco=1.
- Two chained instances (MODULO=10, lower rco -> upper ci) counting up 25 cycles from 0 -> lower=5, upper=2, with the upper stage stepping one cycle after each lower wrap.
